// File: rtl/reflet_regbank.sv
// reflet_regbank: architectural register bank and commit unit.
// Holds general registers, SR, SP and PC; commits one result per non-stalled
// cycle with PC auto-increment, push/pop SP adjustment, latched halt,
// single-level interrupt entry/return and a debug read port.
module reflet_regbank #(
    parameter int unsigned wordsize   = 16,
    parameter int unsigned reg_count  = 16,
    parameter int unsigned sr_id      = reg_count - 3,
    parameter int unsigned sp_id      = reg_count - 2,
    parameter int unsigned pc_id      = reg_count - 1,
    parameter int unsigned sp_init    = 4,
    parameter int unsigned int_vector = 2,
    localparam int unsigned IdxW      = $clog2(reg_count)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                stall,
    input  logic                wr_en,
    input  logic [IdxW-1:0]     wr_idx,
    input  logic [wordsize-1:0] wr_data,
    input  logic [1:0]          sp_op,
    input  logic                quit_req,
    input  logic                int_req,
    input  logic                int_ret,
    input  logic [IdxW-1:0]     rd_a_idx,
    input  logic [IdxW-1:0]     rd_b_idx,
    input  logic [IdxW-1:0]     dbg_idx,
    output logic [wordsize-1:0] rd_a,
    output logic [wordsize-1:0] rd_b,
    output logic [wordsize-1:0] dbg_data,
    output logic [wordsize-1:0] wr_reg,
    output logic [wordsize-1:0] sr,
    output logic [wordsize-1:0] sp,
    output logic [wordsize-1:0] pc,
    output logic                halted,
    output logic                int_active,
    output logic [wordsize-1:0] epc
);

    localparam logic [IdxW-1:0] SrIdx = IdxW'(sr_id);
    localparam logic [IdxW-1:0] SpIdx = IdxW'(sp_id);
    localparam logic [IdxW-1:0] PcIdx = IdxW'(pc_id);

    localparam logic [1:0] SpPush = 2'd1;
    localparam logic [1:0] SpPop  = 2'd2;

    logic [wordsize-1:0] regs_q [reg_count];
    logic [wordsize-1:0] regs_d [reg_count];
    logic                halted_q, halted_d;
    logic                int_active_q, int_active_d;
    logic [wordsize-1:0] epc_q, epc_d;

    logic                commit;
    logic                sp_adjust;
    logic                reg_write;
    logic [wordsize-1:0] pc_next;

    assign commit    = !stall && !halted_q;
    assign sp_adjust = (sp_op == SpPush) || (sp_op == SpPop);
    // A push/pop instruction never performs a general write.
    assign reg_write = wr_en && !sp_adjust;

    // Next-state: register array, PC sequencing, halt and interrupt bookkeeping.
    always_comb begin
        regs_d       = regs_q;
        halted_d     = halted_q;
        int_active_d = int_active_q;
        epc_d        = epc_q;
        pc_next      = regs_q[PcIdx];

        if (commit) begin
            if (sp_op == SpPush) begin
                regs_d[SpIdx] = regs_q[SpIdx] + wordsize'(1);
            end else if (sp_op == SpPop) begin
                regs_d[SpIdx] = regs_q[SpIdx] - wordsize'(1);
            end else if (reg_write) begin
                regs_d[wr_idx] = wr_data;
            end

            if (reg_write && (wr_idx == PcIdx)) begin
                pc_next = wr_data;
            end else begin
                pc_next = regs_q[PcIdx] + wordsize'(1);
            end

            if (quit_req) begin
                halted_d = 1'b1;
            end

            if (int_ret && int_active_q) begin
                pc_next      = epc_q;
                int_active_d = 1'b0;
            end else if (int_req && !int_active_q && !quit_req && !int_ret) begin
                // Save the PC this instruction would have produced.
                epc_d        = pc_next;
                pc_next      = wordsize'(int_vector);
                int_active_d = 1'b1;
            end

            regs_d[PcIdx] = pc_next;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < int'(reg_count); i++) begin
                regs_q[i] <= '0;
            end
            regs_q[SrIdx] <= wordsize'(1);
            regs_q[SpIdx] <= wordsize'(sp_init);
            halted_q      <= 1'b0;
            int_active_q  <= 1'b0;
            epc_q         <= '0;
        end else begin
            regs_q       <= regs_d;
            halted_q     <= halted_d;
            int_active_q <= int_active_d;
            epc_q        <= epc_d;
        end
    end

    // Combinational reads of the stored array; no write-through bypass.
    always_comb begin
        rd_a       = regs_q[rd_a_idx];
        rd_b       = regs_q[rd_b_idx];
        dbg_data   = regs_q[dbg_idx];
        wr_reg     = regs_q[0];
        sr         = regs_q[SrIdx];
        sp         = regs_q[SpIdx];
        pc         = regs_q[PcIdx];
        halted     = halted_q;
        int_active = int_active_q;
        epc        = epc_q;
    end

endmodule

// File: tb/tb_reflet_regbank.sv
// Scoreboard bench for reflet_regbank (default parameters).
module tb_reflet_regbank;

    localparam int SelPc   = 0;
    localparam int SelSp   = 1;
    localparam int SelSr   = 2;
    localparam int SelR0   = 3;
    localparam int SelHalt = 4;
    localparam int SelInt  = 5;
    localparam int SelEpc  = 6;
    localparam int SelRdA  = 7;
    localparam int SelRdB  = 8;
    localparam int SelDbg  = 9;

    logic        clk = 1'b0;
    logic        reset, stall, wr_en, quit_req, int_req, int_ret;
    logic [3:0]  wr_idx, rd_a_idx, rd_b_idx, dbg_idx;
    logic [15:0] wr_data;
    logic [1:0]  sp_op;
    logic [15:0] rd_a, rd_b, dbg_data, wr_reg, sr, sp, pc, epc;
    logic        halted, int_active;

    typedef struct {
        string       tag;
        int          sel;
        logic [3:0]  idx;
        logic [15:0] exp;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    reflet_regbank dut (
        .clk        (clk),
        .reset      (reset),
        .stall      (stall),
        .wr_en      (wr_en),
        .wr_idx     (wr_idx),
        .wr_data    (wr_data),
        .sp_op      (sp_op),
        .quit_req   (quit_req),
        .int_req    (int_req),
        .int_ret    (int_ret),
        .rd_a_idx   (rd_a_idx),
        .rd_b_idx   (rd_b_idx),
        .dbg_idx    (dbg_idx),
        .rd_a       (rd_a),
        .rd_b       (rd_b),
        .dbg_data   (dbg_data),
        .wr_reg     (wr_reg),
        .sr         (sr),
        .sp         (sp),
        .pc         (pc),
        .halted     (halted),
        .int_active (int_active),
        .epc        (epc)
    );

    always #50 clk = ~clk;

    task automatic check_val(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    function automatic logic [15:0] observe(input int sel);
        case (sel)
            SelPc:   return pc;
            SelSp:   return sp;
            SelSr:   return sr;
            SelR0:   return wr_reg;
            SelHalt: return {15'b0, halted};
            SelInt:  return {15'b0, int_active};
            SelEpc:  return epc;
            SelRdA:  return rd_a;
            SelRdB:  return rd_b;
            default: return dbg_data;
        endcase
    endfunction

    task automatic expect_val(input string tag, input int sel, input logic [3:0] idx,
                              input logic [15:0] exp);
        exp_t e;
        e.tag = tag; e.sel = sel; e.idx = idx; e.exp = exp;
        sb.push_back(e);
    endtask

    // Clock one edge, then drain the scoreboard against the settled outputs.
    task automatic step();
        exp_t e;
        @(posedge clk);
        #1;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            rd_a_idx = e.idx;
            rd_b_idx = e.idx;
            dbg_idx  = e.idx;
            #1;
            check_val(e.tag, observe(e.sel), e.exp);
        end
    endtask

    task automatic idle_inputs();
        stall = 0; wr_en = 0; wr_idx = 0; wr_data = 0; sp_op = 0;
        quit_req = 0; int_req = 0; int_ret = 0;
    endtask

    task automatic expect_reset_state(input string tag);
        expect_val({tag, "_pc"}, SelPc, 0, 16'h0000);
        expect_val({tag, "_sp"}, SelSp, 0, 16'h0004);
        expect_val({tag, "_sr"}, SelSr, 0, 16'h0001);
        expect_val({tag, "_halt"}, SelHalt, 0, 16'h0000);
        expect_val({tag, "_int"}, SelInt, 0, 16'h0000);
        expect_val({tag, "_epc"}, SelEpc, 0, 16'h0000);
    endtask

    initial begin
        rd_a_idx = 0; rd_b_idx = 0; dbg_idx = 0;
        idle_inputs();
        reset = 0;

        // Reset held for two edges.
        step();
        expect_reset_state("rst");
        for (int i = 0; i < 13; i++) expect_val("rst_reg", SelDbg, 4'(i), 16'h0000);
        step();

        // Sequential commits.
        reset = 1;
        wr_en = 1; wr_idx = 3; wr_data = 16'hABCD;
        expect_val("wr_r3", SelRdA, 3, 16'hABCD);
        expect_val("wr_pc1", SelPc, 0, 16'h0001);
        step();
        wr_idx = 15; wr_data = 16'h0040;
        expect_val("pc_write", SelPc, 0, 16'h0040);
        step();

        // Push held under stall, then released with a concurrent R0 write.
        stall = 1; sp_op = 1; wr_en = 1; wr_idx = 0; wr_data = 16'h1234;
        for (int i = 0; i < 3; i++) begin
            expect_val("stall_sp", SelSp, 0, 16'h0004);
            expect_val("stall_pc", SelPc, 0, 16'h0040);
            step();
        end
        stall = 0;
        expect_val("push_sp", SelSp, 0, 16'h0005);
        expect_val("push_pc", SelPc, 0, 16'h0041);
        expect_val("push_r0", SelR0, 0, 16'h0000);
        step();

        // Pop down to zero, then wrap below zero.
        idle_inputs(); sp_op = 2;
        for (int i = 0; i < 5; i++) step();
        expect_val("pop_wrap_sp", SelSp, 0, 16'hFFFF);
        expect_val("pop_wrap_pc", SelPc, 0, 16'h0047);
        step();

        // Interrupt round trip.
        idle_inputs(); wr_en = 1; wr_idx = 15; wr_data = 16'h0010;
        step();
        idle_inputs(); int_req = 1;
        expect_val("ent_epc", SelEpc, 0, 16'h0011);
        expect_val("ent_pc", SelPc, 0, 16'h0002);
        expect_val("ent_act", SelInt, 0, 16'h0001);
        step();
        expect_val("nest_pc", SelPc, 0, 16'h0003);
        expect_val("nest_epc", SelEpc, 0, 16'h0011);
        step();
        idle_inputs(); int_ret = 1;
        expect_val("ret_pc", SelPc, 0, 16'h0011);
        expect_val("ret_act", SelInt, 0, 16'h0000);
        step();
        expect_val("ret_idle_pc", SelPc, 0, 16'h0012);
        step();

        // Quit commits its own write, then everything but reset is ignored.
        idle_inputs(); quit_req = 1; wr_en = 1; wr_idx = 2; wr_data = 16'h0007;
        int_req = 1;
        expect_val("quit_r2", SelRdB, 2, 16'h0007);
        expect_val("quit_pc", SelPc, 0, 16'h0013);
        expect_val("quit_halt", SelHalt, 0, 16'h0001);
        expect_val("quit_noint", SelInt, 0, 16'h0000);
        step();
        idle_inputs(); wr_en = 1; wr_idx = 2; wr_data = 16'h0009; int_req = 1; sp_op = 1;
        expect_val("halt_r2", SelRdB, 2, 16'h0007);
        expect_val("halt_pc", SelPc, 0, 16'h0013);
        expect_val("halt_sp", SelSp, 0, 16'hFFFF);
        expect_val("halt_int", SelInt, 0, 16'h0000);
        step();
        reset = 0;
        expect_reset_state("qrst");
        expect_val("qrst_r2", SelDbg, 2, 16'h0000);
        expect_val("qrst_r3", SelDbg, 3, 16'h0000);
        step();

        // PC wrap.
        reset = 1; idle_inputs(); wr_en = 1; wr_idx = 15; wr_data = 16'hFFFF;
        expect_val("pc_ffff", SelPc, 0, 16'hFFFF);
        step();
        idle_inputs();
        expect_val("pc_wrap", SelPc, 0, 16'h0000);
        step();

        // Reset during stall while inside an interrupt handler.
        int_req = 1;
        expect_val("ent2_epc", SelEpc, 0, 16'h0001);
        expect_val("ent2_act", SelInt, 0, 16'h0001);
        step();
        idle_inputs(); stall = 1; wr_en = 1; wr_idx = 5; wr_data = 16'h5555;
        expect_val("stall_pc2", SelPc, 0, 16'h0002);
        expect_val("stall_r5", SelDbg, 5, 16'h0000);
        step();
        reset = 0;
        expect_reset_state("srst");
        step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
